// File: rtl/pintar_matriz_scan.sv
// Row-multiplexed LED matrix painter: shows a glyph or an external game frame,
// latching its source only at frame boundaries and blinking the win/lose glyphs.
module pintar_matriz_scan #(
  parameter int ROWS           = 8,
  parameter int COLS           = 8,
  parameter int SEL_W          = 3,
  parameter int SCAN_DIV       = 6250,
  parameter int BLINK_FRAMES   = 64,
  parameter int ROW_ACTIVE_LOW = 0,
  parameter int JUEGO_CODE     = 7
) (
  input  logic                 PINTAR_SCAN_CLOCK_50,
  input  logic                 PINTAR_SCAN_RESET_InLow,
  input  logic                 PINTAR_SCAN_ENABLE_In,
  input  logic [SEL_W-1:0]     PINTAR_SCAN_ESTADO_In,
  input  logic [ROWS*COLS-1:0] PINTAR_SCAN_FRAME_In,
  output logic [ROWS-1:0]      PINTAR_SCAN_ROW_Out,
  output logic [COLS-1:0]      PINTAR_SCAN_COL_Out,
  output logic                 PINTAR_SCAN_FRAME_DONE_Out
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int RW = $clog2(ROWS);
  localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [RW-1:0]   ROW_LAST   = RW'(ROWS - 1);
  localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [ROWS-1:0] ROW_IDLE   = {ROWS{ROW_ACTIVE_LOW != 0}};

  logic [PW-1:0]        presc_reg;
  logic [RW-1:0]        row_idx_reg;
  logic [SEL_W-1:0]     estado_reg;
  logic [ROWS*COLS-1:0] frame_reg;
  logic [BW-1:0]        blink_cnt_reg;
  logic                 phase_reg;
  logic [ROWS-1:0]      row_out_reg;
  logic [COLS-1:0]      col_out_reg;
  logic                 done_reg;

  logic            tick;
  logic            frame_end;
  logic            blink_off;
  logic [63:0]     glyph_bits;
  logic [COLS-1:0] row_pattern;
  logic [ROWS-1:0] row_onehot;

  assign tick      = PINTAR_SCAN_ENABLE_In && (presc_reg == PRESC_LAST);
  assign frame_end = tick && (row_idx_reg == ROW_LAST);
  assign blink_off = phase_reg &&
                     ((estado_reg == SEL_W'(5)) || (estado_reg == SEL_W'(6)));

  // Glyph rows packed with row 7 in the top byte, bit 7 = column 7.
  always_comb begin
    glyph_bits = '0;
    case (estado_reg)
      SEL_W'(0): glyph_bits = 64'hFFFF_1818_1818_FFFF;
      SEL_W'(1): glyph_bits = 64'h0818_0808_0808_081C;
      SEL_W'(2): glyph_bits = 64'h3C42_0204_0810_207E;
      SEL_W'(3): glyph_bits = 64'h3C42_021C_0202_423C;
      SEL_W'(4): glyph_bits = 64'h040C_1424_7E04_0404;
      SEL_W'(5): glyph_bits = 64'h0001_0204_8850_2000;
      SEL_W'(6): glyph_bits = 64'h8142_2418_1824_4281;
      default:   glyph_bits = '0;
    endcase
  end

  always_comb begin
    row_pattern = '0;
    if (estado_reg == SEL_W'(JUEGO_CODE)) begin
      row_pattern = frame_reg[row_idx_reg * COLS +: COLS];
    end else if (int'(row_idx_reg) < 8) begin
      row_pattern[7:0] = glyph_bits[{row_idx_reg[2:0], 3'b000} +: 8];
    end
    if (blink_off) begin
      row_pattern = '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row_sel
      assign row_onehot[gi] = (row_idx_reg == RW'(gi));
    end
  endgenerate

  always_ff @(posedge PINTAR_SCAN_CLOCK_50 or negedge PINTAR_SCAN_RESET_InLow) begin
    if (!PINTAR_SCAN_RESET_InLow) begin
      presc_reg     <= '0;
      row_idx_reg   <= '0;
      estado_reg    <= '0;
      frame_reg     <= '0;
      blink_cnt_reg <= '0;
      phase_reg     <= 1'b0;
      row_out_reg   <= ROW_IDLE;
      col_out_reg   <= '0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= frame_end;
      if (PINTAR_SCAN_ENABLE_In) begin
        row_out_reg <= row_onehot ^ ROW_IDLE;
        col_out_reg <= row_pattern;
        presc_reg   <= tick ? '0 : presc_reg + PW'(1);
        if (tick) begin
          row_idx_reg <= (row_idx_reg == ROW_LAST) ? '0 : row_idx_reg + RW'(1);
        end
        // Sources are only sampled here, so a frame is never painted from two states.
        if (frame_end) begin
          estado_reg <= PINTAR_SCAN_ESTADO_In;
          if (PINTAR_SCAN_ESTADO_In == SEL_W'(JUEGO_CODE)) begin
            frame_reg <= PINTAR_SCAN_FRAME_In;
          end
          if (PINTAR_SCAN_ESTADO_In != estado_reg) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
          end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
          end else begin
            blink_cnt_reg <= blink_cnt_reg + BW'(1);
          end
        end
      end else begin
        row_out_reg <= ROW_IDLE;
        col_out_reg <= '0;
      end
    end
  end

  assign PINTAR_SCAN_ROW_Out        = row_out_reg;
  assign PINTAR_SCAN_COL_Out        = col_out_reg;
  assign PINTAR_SCAN_FRAME_DONE_Out = done_reg;

endmodule

// File: tb/tb_pintar_matriz_scan.sv
// Bench for pintar_matriz_scan: two instances (active-high and active-low rows)
// driven in lockstep and checked against a frame/slot arithmetic model.
module tb_pintar_matriz_scan;

  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME_CYC = SD * 8;

  localparam logic [7:0] GLY [0:6][0:7] = '{
    '{8'hFF, 8'hFF, 8'h18, 8'h18, 8'h18, 8'h18, 8'hFF, 8'hFF},
    '{8'h08, 8'h18, 8'h08, 8'h08, 8'h08, 8'h08, 8'h08, 8'h1C},
    '{8'h3C, 8'h42, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h7E},
    '{8'h3C, 8'h42, 8'h02, 8'h1C, 8'h02, 8'h02, 8'h42, 8'h3C},
    '{8'h04, 8'h0C, 8'h14, 8'h24, 8'h7E, 8'h04, 8'h04, 8'h04},
    '{8'h00, 8'h01, 8'h02, 8'h04, 8'h88, 8'h50, 8'h20, 8'h00},
    '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81}
  };

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [2:0]  estado;
  logic [63:0] frame_in;
  logic [7:0]  row_out, row_al, col_out, col_al;
  logic        done_out, done_al;

  int n_cmp, n_fail;
  int m_t, m_code, m_n, last_t;
  logic [63:0] m_frame;
  logic [7:0]  exp_row, exp_col;
  logic        exp_done;

  pintar_matriz_scan #(
    .ROWS(8), .COLS(8), .SEL_W(3), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
    .ROW_ACTIVE_LOW(0), .JUEGO_CODE(7)
  ) dut (
    .PINTAR_SCAN_CLOCK_50      (clk),
    .PINTAR_SCAN_RESET_InLow   (rst_n),
    .PINTAR_SCAN_ENABLE_In     (en),
    .PINTAR_SCAN_ESTADO_In     (estado),
    .PINTAR_SCAN_FRAME_In      (frame_in),
    .PINTAR_SCAN_ROW_Out       (row_out),
    .PINTAR_SCAN_COL_Out       (col_out),
    .PINTAR_SCAN_FRAME_DONE_Out(done_out)
  );

  pintar_matriz_scan #(
    .ROWS(8), .COLS(8), .SEL_W(3), .SCAN_DIV(SD), .BLINK_FRAMES(BF),
    .ROW_ACTIVE_LOW(1), .JUEGO_CODE(7)
  ) dut_al (
    .PINTAR_SCAN_CLOCK_50      (clk),
    .PINTAR_SCAN_RESET_InLow   (rst_n),
    .PINTAR_SCAN_ENABLE_In     (en),
    .PINTAR_SCAN_ESTADO_In     (estado),
    .PINTAR_SCAN_FRAME_In      (frame_in),
    .PINTAR_SCAN_ROW_Out       (row_al),
    .PINTAR_SCAN_COL_Out       (col_al),
    .PINTAR_SCAN_FRAME_DONE_Out(done_al)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected column byte: frame source, glyph or blank, with blink from frames-since-latch.
  function automatic logic [7:0] model_col(input int code, input logic [63:0] frm,
                                           input int r, input int n);
    if (code == 7) return frm[r*8 +: 8];
    if (code > 6) return 8'h00;
    if ((code == 5 || code == 6) && ((n / BF) % 2 == 1)) return 8'h00;
    return GLY[code][7-r];
  endfunction

  task automatic model_reset();
    m_t = 0; m_code = 0; m_n = 0; m_frame = '0;
    exp_row = 8'h00; exp_col = 8'h00; exp_done = 1'b0;
  endtask

  // One clock: the model consumes the inputs present at the edge, then outputs settle.
  task automatic cycle();
    int r;
    @(posedge clk);
    last_t = -1;
    if (!rst_n) begin
      model_reset();
    end else begin
      exp_done = 1'b0;
      if (en) begin
        r = (m_t / SD) % 8;
        last_t = m_t;
        exp_row = 8'(1 << r);
        exp_col = model_col(m_code, m_frame, r, m_n);
        m_t++;
        if (m_t % FRAME_CYC == 0) begin
          exp_done = 1'b1;
          if (int'(estado) != m_code) m_n = 0; else m_n++;
          m_code = int'(estado);
          if (estado == 3'd7) m_frame = frame_in;
          $display("frame %0d done: next code=%0d blink_n=%0d", m_t / FRAME_CYC, m_code, m_n);
        end
      end else begin
        exp_row = 8'h00;
        exp_col = 8'h00;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; estado = 3'd0; frame_in = '0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (row_out !== 8'h00 || row_al !== 8'hFF || col_out !== 8'h00 || col_al !== 8'h00 ||
        done_out !== 1'b0 || done_al !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async row=%h/%h col=%h/%h done=%b/%b required row=00/FF col=00 done=0",
               row_out, row_al, col_out, col_al, done_out, done_al);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (row_out !== exp_row || row_al !== ~exp_row || col_out !== exp_col ||
          col_al !== exp_col || done_out !== exp_done || done_al !== exp_done) begin
        n_fail++;
        $display("FAIL reset_hold row=%h/%h col=%h/%h done=%b/%b required row=%h col=%h done=%b",
                 row_out, row_al, col_out, col_al, done_out, done_al, exp_row, exp_col, exp_done);
      end
    end
  endtask

  task automatic test_scan_inicio();
    int pulses;
    pulses = 0;
    @(negedge clk) rst_n = 1'b1;
    while (m_t < 64) begin
      cycle();
      if (done_out === 1'b1) pulses++;
      n_cmp++;
      if (row_out !== exp_row || row_al !== ~exp_row || col_out !== exp_col ||
          col_al !== exp_col || done_out !== exp_done || done_al !== exp_done) begin
        n_fail++;
        $display("FAIL scan_inicio t=%0d row=%h/%h col=%h/%h done=%b/%b required row=%h col=%h done=%b",
                 last_t, row_out, row_al, col_out, col_al, done_out, done_al, exp_row, exp_col, exp_done);
      end
      if (last_t == 0 || last_t == 8 || last_t == 31) begin
        n_cmp++;
        if ((last_t == 0 && (row_out !== 8'h01 || col_out !== 8'hFF)) ||
            (last_t == 8 && (row_out !== 8'h04 || col_out !== 8'h18)) ||
            (last_t == 31 && done_out !== 1'b1)) begin
          n_fail++;
          $display("FAIL scan_inicio_fixed t=%0d row=%h col=%h done=%b required t0:01/FF t8:04/18 t31:done=1",
                   last_t, row_out, col_out, done_out);
        end
      end
    end
    n_cmp++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL frame_done_count got=%0d required=2", pulses);
    end
  endtask

  task automatic test_state_change();
    while (m_t < 128) begin
      if (m_t == 77) estado = 3'd6;
      cycle();
      n_cmp++;
      if (row_out !== exp_row || row_al !== ~exp_row || col_out !== exp_col ||
          col_al !== exp_col || done_out !== exp_done || done_al !== exp_done) begin
        n_fail++;
        $display("FAIL state_change t=%0d row=%h/%h col=%h/%h done=%b/%b required row=%h col=%h done=%b",
                 last_t, row_out, row_al, col_out, col_al, done_out, done_al, exp_row, exp_col, exp_done);
      end
      if (last_t == 84 || last_t == 96 || last_t == 108) begin
        n_cmp++;
        if ((last_t == 84 && col_out !== 8'h18) ||
            (last_t == 96 && (row_out !== 8'h01 || col_out !== 8'h81)) ||
            (last_t == 108 && (row_out !== 8'h08 || col_out !== 8'h18))) begin
          n_fail++;
          $display("FAIL state_change_fixed t=%0d row=%h col=%h required t84:col18 t96:01/81 t108:08/18",
                   last_t, row_out, col_out);
        end
      end
    end
  endtask

  task automatic test_blink();
    estado = 3'd5;
    while (m_t < 448) begin
      if (m_t == 320) estado = 3'd1;
      cycle();
      n_cmp++;
      if (row_out !== exp_row || row_al !== ~exp_row || col_out !== exp_col ||
          col_al !== exp_col || done_out !== exp_done || done_al !== exp_done) begin
        n_fail++;
        $display("FAIL blink t=%0d row=%h/%h col=%h/%h done=%b/%b required row=%h col=%h done=%b",
                 last_t, row_out, row_al, col_out, col_al, done_out, done_al, exp_row, exp_col, exp_done);
      end
      if (last_t == 172 || last_t == 204 || last_t == 300) begin
        n_cmp++;
        if (row_out !== 8'h08 || col_out !== 8'h88) begin
          n_fail++;
          $display("FAIL blink_on t=%0d row=%h col=%h required row=08 col=88", last_t, row_out, col_out);
        end
      end
      if (last_t == 236 || last_t == 268) begin
        n_cmp++;
        if (row_out !== 8'h08 || col_out !== 8'h00) begin
          n_fail++;
          $display("FAIL blink_off t=%0d row=%h col=%h required row=08 col=00", last_t, row_out, col_out);
        end
      end
      if (last_t == 364 || last_t == 396 || last_t == 428) begin
        n_cmp++;
        if (col_out !== 8'h08) begin
          n_fail++;
          $display("FAIL no_blink_code1 t=%0d col=%h required col=08", last_t, col_out);
        end
      end
    end
  endtask

  task automatic test_juego_frame();
    estado = 3'd7;
    frame_in = {$urandom, $urandom};
    frame_in[23:16] = 8'hA5;
    while (m_t < 544) begin
      if (m_t == 500) frame_in[23:16] = 8'h5A;
      cycle();
      n_cmp++;
      if (row_out !== exp_row || row_al !== ~exp_row || col_out !== exp_col ||
          col_al !== exp_col || done_out !== exp_done || done_al !== exp_done) begin
        n_fail++;
        $display("FAIL juego t=%0d row=%h/%h col=%h/%h done=%b/%b required row=%h col=%h done=%b",
                 last_t, row_out, row_al, col_out, col_al, done_out, done_al, exp_row, exp_col, exp_done);
      end
      if (last_t == 488 || last_t == 520) begin
        n_cmp++;
        if ((last_t == 488 && col_out !== 8'hA5) || (last_t == 520 && col_out !== 8'h5A)) begin
          n_fail++;
          $display("FAIL juego_row2 t=%0d col=%h required t488:A5 t520:5A", last_t, col_out);
        end
      end
    end
  endtask

  task automatic test_enable();
    while (m_t < 565) begin
      cycle();
      n_cmp++;
      if (row_out !== exp_row || row_al !== ~exp_row || col_out !== exp_col ||
          col_al !== exp_col || done_out !== exp_done || done_al !== exp_done) begin
        n_fail++;
        $display("FAIL enable_pre t=%0d row=%h/%h col=%h/%h done=%b/%b required row=%h col=%h done=%b",
                 last_t, row_out, row_al, col_out, col_al, done_out, done_al, exp_row, exp_col, exp_done);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_cmp++;
      if (row_out !== 8'h00 || row_al !== 8'hFF || col_out !== 8'h00 || col_al !== 8'h00 ||
          done_out !== 1'b0 || done_al !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_low i=%0d row=%h/%h col=%h/%h done=%b/%b required row=00/FF col=00 done=0",
                 i, row_out, row_al, col_out, col_al, done_out, done_al);
      end
    end
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++;
      if (row_out !== ((i < 3) ? 8'h20 : 8'h40) || row_al !== ~exp_row || col_out !== exp_col) begin
        n_fail++;
        $display("FAIL enable_resume i=%0d row=%h col=%h required row=%h col=%h",
                 i, row_out, col_out, (i < 3) ? 8'h20 : 8'h40, exp_col);
      end
    end
    // Frame end on the same edge that enable drops.
    while (m_t < 608) begin
      if (m_t == 600) estado = 3'd3;
      cycle();
      n_cmp++;
      if (row_out !== exp_row || row_al !== ~exp_row || col_out !== exp_col ||
          col_al !== exp_col || done_out !== exp_done || done_al !== exp_done) begin
        n_fail++;
        $display("FAIL enable_edge t=%0d row=%h/%h col=%h/%h done=%b/%b required row=%h col=%h done=%b",
                 last_t, row_out, row_al, col_out, col_al, done_out, done_al, exp_row, exp_col, exp_done);
      end
    end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_cmp++;
      if (row_out !== 8'h00 || col_out !== 8'h00 || done_out !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_fall_blank i=%0d row=%h col=%h done=%b required 00/00/0",
                 i, row_out, col_out, done_out);
      end
    end
    en = 1'b1;
    cycle();
    n_cmp++;
    if (row_out !== 8'h01 || col_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL enable_fall_latch row=%h col=%h required row=01 col=3C", row_out, col_out);
    end
  endtask

  task automatic test_async_reset();
    estado = 3'd6;
    while (m_t < 650) begin
      cycle();
      n_cmp++;
      if (row_out !== exp_row || row_al !== ~exp_row || col_out !== exp_col ||
          col_al !== exp_col || done_out !== exp_done || done_al !== exp_done) begin
        n_fail++;
        $display("FAIL pre_reset t=%0d row=%h/%h col=%h/%h done=%b/%b required row=%h col=%h done=%b",
                 last_t, row_out, row_al, col_out, col_al, done_out, done_al, exp_row, exp_col, exp_done);
      end
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (row_al !== 8'hFF || row_out !== 8'h00 || col_al !== 8'h00 || col_out !== 8'h00 ||
        done_al !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midframe row=%h/%h col=%h/%h done=%b required row=00/FF col=00 done=0",
               row_out, row_al, col_out, col_al, done_al);
    end
    cycle();
    cycle();
    @(negedge clk) rst_n = 1'b1;
    cycle();
    n_cmp++;
    if (row_out !== 8'h01 || row_al !== 8'hFE || col_out !== 8'hFF || col_al !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_release row=%h/%h col=%h/%h required row=01/FE col=FF",
               row_out, row_al, col_out, col_al);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 119) == 0) estado = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) frame_in = {$urandom, $urandom};
      if (en) en = ($urandom_range(0, 19) != 0);
      else    en = ($urandom_range(0, 3) == 0);
      cycle();
      n_cmp++;
      if (row_out !== exp_row || row_al !== ~exp_row || col_out !== exp_col ||
          col_al !== exp_col || done_out !== exp_done || done_al !== exp_done) begin
        n_fail++;
        $display("FAIL random i=%0d t=%0d row=%h/%h col=%h/%h done=%b/%b required row=%h col=%h done=%b",
                 i, last_t, row_out, row_al, col_out, col_al, done_out, done_al, exp_row, exp_col, exp_done);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    last_t = -1;
    model_reset();
    test_reset();
    test_scan_inicio();
    test_state_change();
    test_blink();
    test_juego_frame();
    test_enable();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
